// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - TMDS word width, control token codes and alignment states
package tmds_pkg;

  localparam int WORD_W = 10;

  // Token values are written MSB..LSB; bit 0 is the first bit on the wire.
  localparam logic [WORD_W-1:0] CTRL_TOK0 = 10'b1101010100;
  localparam logic [WORD_W-1:0] CTRL_TOK1 = 10'b0010101011;
  localparam logic [WORD_W-1:0] CTRL_TOK2 = 10'b0101010100;
  localparam logic [WORD_W-1:0] CTRL_TOK3 = 10'b1010101011;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

endpackage

// File: rtl/tmds_token_match.sv
// rtl/tmds_token_match.sv - combinational detector for the four TMDS control tokens
module tmds_token_match
  import tmds_pkg::*;
(
  input  logic [WORD_W-1:0] sr,
  output logic              hit,
  output logic [1:0]        ctrl
);

  always_comb begin
    hit  = 1'b1;
    ctrl = 2'b00;
    case (sr)
      CTRL_TOK0: ctrl = 2'b00;
      CTRL_TOK1: ctrl = 2'b01;
      CTRL_TOK2: ctrl = 2'b10;
      CTRL_TOK3: ctrl = 2'b11;
      default:   hit  = 1'b0;
    endcase
  end

endmodule

// File: rtl/tmds_deserializer.sv
// rtl/tmds_deserializer.sv - serial-to-parallel TMDS receiver with control-token word alignment
module tmds_deserializer
  import tmds_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int MISS_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_in,
  output logic [WORD_W-1:0] word,
  output logic              word_valid,
  output logic [1:0]        ctrl,
  output logic              ctrl_valid,
  output logic              locked
);

  localparam logic [1:0] ST_SEARCH = SEARCH;
  localparam logic [1:0] ST_VERIFY = VERIFY;
  localparam logic [1:0] ST_LOCKED = LOCKED;
  localparam logic [3:0] LOCK_N    = 4'(LOCK_COUNT);
  localparam logic [3:0] MISS_N    = 4'(MISS_LIMIT);

  logic [WORD_W-1:0] sr;
  logic [3:0]        phase;
  logic [1:0]        state;
  logic [3:0]        good_cnt;
  logic [3:0]        miss_cnt;
  logic              hit;
  logic [1:0]        tok_ctrl;
  logic              boundary;
  logic [3:0]        miss_inc;

  tmds_token_match u_match (
    .sr   (sr),
    .hit  (hit),
    .ctrl (tok_ctrl)
  );

  // Phase 9 marks the cycle in which sr holds a complete aligned word.
  assign boundary = (phase == 4'd9);
  assign miss_inc = (miss_cnt == 4'hF) ? miss_cnt : miss_cnt + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr         <= '0;
      phase      <= '0;
      state      <= ST_SEARCH;
      good_cnt   <= '0;
      miss_cnt   <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      ctrl       <= 2'b00;
      ctrl_valid <= 1'b0;
      locked     <= 1'b0;
    end else begin
      sr         <= {s_in, sr[WORD_W-1:1]};
      phase      <= boundary ? 4'd0 : phase + 4'd1;
      word_valid <= 1'b0;
      case (state)
        ST_SEARCH: begin
          if (hit) begin
            phase    <= 4'd0;
            good_cnt <= 4'd1;
            if (LOCK_COUNT == 1) begin
              state    <= ST_LOCKED;
              locked   <= 1'b1;
              miss_cnt <= '0;
            end else begin
              state <= ST_VERIFY;
            end
          end
        end
        ST_VERIFY: begin
          if (boundary) begin
            if (hit) begin
              good_cnt <= good_cnt + 4'd1;
              if (good_cnt + 4'd1 == LOCK_N) begin
                state    <= ST_LOCKED;
                locked   <= 1'b1;
                miss_cnt <= '0;
              end
            end else begin
              state    <= ST_SEARCH;
              good_cnt <= '0;
            end
          end
        end
        ST_LOCKED: begin
          if (boundary) begin
            word       <= sr;
            word_valid <= 1'b1;
            ctrl_valid <= hit;
            ctrl       <= tok_ctrl;
            if (hit) miss_cnt <= '0;
          end else if (hit) begin
            // A token seen off-phase means the link slipped; tolerate a few before dropping lock.
            if (miss_inc >= MISS_N) begin
              state    <= ST_SEARCH;
              locked   <= 1'b0;
              good_cnt <= '0;
              miss_cnt <= '0;
            end else begin
              miss_cnt <= miss_inc;
            end
          end
        end
        default: begin
          state  <= ST_SEARCH;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/tmds_deserializer.md
Name: tmds_deserializer

Overview:
Single-channel TMDS receiver front end. Turns the LSB-first serial bit stream back into 10-bit TMDS words. It finds the word boundary by detecting the four DVI/HDMI control tokens, and reports lock status and decoded control bits. It sits between the input bit sampler (one bit per clk) and the TMDS 8b/10b decoder; one instance is used per colour channel.

Parameters:
LOCK_COUNT, 4, consecutive aligned control tokens required to move from VERIFY to LOCKED (1..15)
MISS_LIMIT, 8, misaligned-token events tolerated in LOCKED before returning to SEARCH (1..15)

Ports:
clk  input  1  bit clock; one serial bit sampled per rising edge
rst_n  input  1  asynchronous active-low reset
s_in  input  1  serial TMDS bit; token bit 0 arrives first
word  output  10  aligned TMDS word, bit 0 = first received bit
word_valid  output  1  one-cycle pulse per aligned word, only while locked
ctrl  output  2  decoded control bits of the current word
ctrl_valid  output  1  word is a control token (data-enable low); qualified by word_valid
locked  output  1  alignment achieved

Behaviour:
- Reset (async, rst_n=0): shift register=0, phase=0, state=SEARCH, counters=0. word=0, word_valid=0, ctrl=0, ctrl_valid=0, locked=0. Reset takes effect immediately, including mid-word; no partial word is emitted afterwards.
- Shift register: sr <= {s_in, sr[9:1]} every clk. After 10 bits, sr[0] is the first bit received.
- Token match (combinational on sr):
  - 1101010100 -> ctrl 00
  - 0010101011 -> ctrl 01
  - 0101010100 -> ctrl 10
  - 1010101011 -> ctrl 11
  - hit = any match.
- Phase counter: 0..9, wraps 9->0. A boundary is the cycle in which phase is at its boundary value, i.e. every 10th bit after the last (re)alignment.
- SEARCH:
  - On hit at any cycle: realign the phase so that this cycle is the boundary. Set good_cnt=1 and go to VERIFY; if LOCK_COUNT=1, go straight to LOCKED.
  - Otherwise remain in SEARCH.
- VERIFY:
  - Evaluated only at boundaries. Hit: good_cnt++; when good_cnt reaches LOCK_COUNT, go to LOCKED and clear miss_cnt.
  - No hit at a boundary: go to SEARCH.
  - Hits at non-boundary cycles are ignored.
- LOCKED:
  - At every boundary: register word<=sr, pulse word_valid, ctrl_valid<=hit, ctrl<=matched code (00 when no hit). A boundary hit clears miss_cnt.
  - A hit at a non-boundary cycle increments miss_cnt (saturating). When miss_cnt reaches MISS_LIMIT, go to SEARCH the next cycle; no further word_valid pulses.
  - A boundary hit and a non-boundary hit cannot fall in the same cycle; no priority rule is needed.
- locked = (state==LOCKED), registered. It drops in the same cycle the state leaves LOCKED.
- Latency: the word whose last bit is sampled at edge N appears on word with word_valid high after edge N+1 (1 clk). word_valid period is exactly 10 clk while locked.
- word, ctrl and ctrl_valid hold their values between pulses. When lock is lost they keep their last values; word_valid is forced to 0.
- Re-entry from LOCKED to SEARCH clears good_cnt and miss_cnt. The sr contents are kept, so an immediate hit is allowed to start VERIFY.

Decomposition:
- Package tmds_pkg:
  - WORD_W=10
  - CTRL_TOK0..3 constants
  - state enum {SEARCH, VERIFY, LOCKED}
  - shared with the encoder/serializer side.
- Sub-module tmds_token_match: combinational, in sr[9:0], out hit and ctrl[1:0]. It is reused later by the channel-deskew block.

Test Plan:
1. Reset, then stream ctrl token 1101010100 repeatedly, starting at bit offset 3 after random bits. Required: locked rises 1 clk after the 4th aligned token completes. First word_valid shows word=0x354, ctrl_valid=1, ctrl=00. Pulses then repeat every 10 clk.
2. After lock, send 12 tokens then data words 0x1F0, 0x2A5, then tokens 0x0AB. Required: word matches each in order with ctrl_valid 1,…,0,0,1, and ctrl=01 on the 0x0AB token. locked stays 1.
3. While locked, insert one extra bit into a blanking period of tokens. Required: locked falls after the 8th misaligned token. The block then relocks at the new phase 4 tokens later, and words are correct again.
4. In VERIFY (after 2 aligned tokens), send data word 0x1F0 at a boundary. Required: return to SEARCH, locked never asserts, and lock needs 4 fresh aligned tokens.
5. Assert rst_n low for 1 clk mid-word while locked. Required: all outputs 0 immediately (asynchronous). No word_valid until relock; relock completes after 4 tokens.
6. Stream all four tokens cyclically after lock. Required: ctrl sequence 00,01,10,11 and ctrl_valid=1 on every pulse.
